position_register_file: RTL and testbench
=========================================

# position_register_file

Board storage stage fed directly by the position decoder's one-hot write enables. Holds the nine cells of the tic-tac-toe board, accepts one move per request, rejects illegal moves, and tracks move count, win lines and draw. Its board and status outputs go to the display/VGA path and the FSM controller.

## Interface
Parameters: none. Cell encoding is fixed: 2'b00 empty, 2'b01 player (X), 2'b10 computer (O).

- clock  in  1  single system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-low reset
- player_en  in  16  one-hot write enable from the player-side decoder; bit k selects cell k
- computer_en  in  16  one-hot write enable from the computer-side decoder; bit k selects cell k
- clear  in  1  synchronous new-game clear, active-high
- board  out  18  cell k (k=1..9) on bits [2k-1:2k-2]
- write_done  out  1  one-cycle pulse: move accepted
- illegal_move  out  1  one-cycle pulse: move rejected
- move_count  out  4  accepted moves since reset/clear, 0..9
- board_full  out  1  move_count == 9
- winner  out  2  00 none, 01 player, 10 computer, 11 draw
- game_over  out  1  winner != 00

## Operation
- **Request.** A request is any cycle in which player_en or computer_en is nonzero. All-zero inputs mean idle: no pulses, no change.
- **Accepted move.** A request is valid only when all of the following hold:
  - state is PLAY;
  - exactly one of the two vectors is nonzero;
  - that vector has exactly one bit set;
  - the set bit index k is in 1..9;
  - cell k is empty.
- **Valid request.** Cell k is written (01 for player, 10 for computer), move_count increments, write_done pulses, and the state goes to EVAL.
- **Invalid request.** illegal_move pulses and nothing else changes. Causes: occupied cell, bit 0 or bits 10..15, multiple bits, both vectors nonzero, state EVAL or OVER.
- **State machine:**
  - PLAY → EVAL on an accepted move.
  - EVAL → OVER if the win/draw check is nonzero.
  - EVAL → PLAY otherwise.
  - OVER holds until clear or reset.
- **Win check (EVAL, on registered board).**
  - Lines: rows (1,2,3)(4,5,6)(7,8,9); columns (1,4,7)(2,5,8)(3,6,9); diagonals (1,5,9)(3,5,7).
  - A line wins when all three cells are equal and non-empty.
  - Player line gives 01; otherwise computer line gives 10.
  - If there is no line and move_count == 9, the result is 11; otherwise 00.
  - If both players have lines (unreachable in legal play), 01 takes priority.
- **Clear and reset.** Both have identical effect and take priority over any request in the same cycle: board, flags and counter cleared; state to PLAY.

## Timing
- **Reset values:** board = 0, write_done = 0, illegal_move = 0, move_count = 0, board_full = 0, winner = 00, game_over = 0, state PLAY.
- **Accepted request sampled at edge N:**
  - After edge N: board, move_count and board_full are updated and write_done is high for exactly one cycle.
  - After edge N+1: winner and game_over are updated and the state is PLAY or OVER.
  - Minimum spacing between accepted moves is 2 cycles.
- **Rejected request sampled at edge N:** illegal_move is high for one cycle after edge N.
- **Request in EVAL:** always rejected, even when it targets an empty cell. The upstream FSM waits one cycle after write_done.
- **Back-to-back requests:** each one produces its own pulse. Pulses never merge: a held request in OVER gives illegal_move high every cycle.
- **Status hold:** winner and game_over are held until clear or reset. board_full can be 1 with winner = 01 or 10 (ninth move wins).
- **Saturation:** move_count never exceeds 9, because in a legal sequence the game is OVER by then.
- **Reset or clear during EVAL:** aborts the evaluation; winner stays 00.

## Test plan
- **Reset, then single move.** Reset low 2 cycles, then player_en = 16'h0020. Expect board = 18'h00100 (cell 5 = 01), move_count = 1, write_done pulse one cycle later, winner = 00 after EVAL.
- **Rejected requests.** Each produces an illegal_move pulse with board unchanged:
  - computer_en = 16'h0020 onto occupied cell 5;
  - player_en = 16'h0001 (bit 0);
  - player_en = 16'h0400 (bit 10);
  - player_en = 16'h0006 (two bits);
  - player_en and computer_en both nonzero.
- **Player row win.** Player cells 1, 2, 3 with computer cells 4, 5 interleaved, each request 2 cycles apart. Expect winner = 01 and game_over = 1 one cycle after the final write_done; a further request gives illegal_move.
- **Draw.** Fill order X1 O2 X3 O5 X4 O6 X8 O7 X9. Expect move_count = 9, board_full = 1, winner = 11.
- **Request during EVAL.** Issue a valid request in the cycle right after write_done. Expect illegal_move and no board change.
- **Clear and mid-game reset.** Assert clear during OVER together with a request. Expect all outputs back to reset values, no pulse, and the next request accepted. Repeat with reset low mid-game; same result.

Source files
------------

// File: rtl/position_register_file_if.sv
// Move-request and board-status bundle between the position decoders,
// the board storage stage and its consumers (display path, FSM controller).
interface position_register_file_if;
  logic [15:0] player_en;
  logic [15:0] computer_en;
  logic        clear;
  logic [17:0] board;
  logic        write_done;
  logic        illegal_move;
  logic [3:0]  move_count;
  logic        board_full;
  logic [1:0]  winner;
  logic        game_over;

  modport master (
    output player_en, computer_en, clear,
    input  board, write_done, illegal_move, move_count, board_full, winner, game_over
  );

  modport slave (
    input  player_en, computer_en, clear,
    output board, write_done, illegal_move, move_count, board_full, winner, game_over
  );
endinterface

// File: rtl/position_register_file.sv
// Tic-tac-toe board storage: accepts one legal move per request, rejects the
// rest, then spends one cycle judging the registered board for a win or draw.
module position_register_file (
  input  logic                           clock,
  input  logic                           reset,
  position_register_file_if.slave        bus
);
  typedef enum logic [1:0] {PLAY = 2'd0, EVAL = 2'd1, OVER = 2'd2} state_t;
  typedef logic [9:1][1:0] board_t;

  state_t      state_q, state_d;
  board_t      board_q, board_d;
  logic [3:0]  move_count_q, move_count_d;
  logic [1:0]  winner_q, winner_d;
  logic        write_done_q, write_done_d;
  logic        illegal_move_q, illegal_move_d;

  logic        p_any, c_any, request, target_empty, accept;
  logic [15:0] sel;

  function automatic logic [1:0] line_owner(input logic [1:0] a, input logic [1:0] b,
                                            input logic [1:0] c);
    return (a != 2'b00 && a == b && b == c) ? a : 2'b00;
  endfunction

  // Player lines outrank computer lines; a full board with no line is a draw.
  function automatic logic [1:0] evaluate(input board_t b, input logic [3:0] cnt);
    logic [7:0][1:0] own;
    logic            x_line;
    logic            o_line;
    own[0] = line_owner(b[1], b[2], b[3]);
    own[1] = line_owner(b[4], b[5], b[6]);
    own[2] = line_owner(b[7], b[8], b[9]);
    own[3] = line_owner(b[1], b[4], b[7]);
    own[4] = line_owner(b[2], b[5], b[8]);
    own[5] = line_owner(b[3], b[6], b[9]);
    own[6] = line_owner(b[1], b[5], b[9]);
    own[7] = line_owner(b[3], b[5], b[7]);
    x_line = 1'b0;
    o_line = 1'b0;
    for (int i = 0; i < 8; i++) begin
      x_line = x_line | (own[i[2:0]] == 2'b01);
      o_line = o_line | (own[i[2:0]] == 2'b10);
    end
    if (x_line)           return 2'b01;
    else if (o_line)      return 2'b10;
    else if (cnt == 4'd9) return 2'b11;
    else                  return 2'b00;
  endfunction

  always_comb begin
    p_any   = |bus.player_en;
    c_any   = |bus.computer_en;
    request = p_any | c_any;
    sel     = p_any ? bus.player_en : bus.computer_en;
    target_empty = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      if (sel[k[3:0]] && board_q[k[3:0]] == 2'b00) target_empty = 1'b1;
    end
    accept = (state_q == PLAY) && (p_any ^ c_any) && $onehot(sel) &&
             !sel[0] && (sel[15:10] == 6'd0) && target_empty;
  end

  always_comb begin
    state_d        = state_q;
    board_d        = board_q;
    move_count_d   = move_count_q;
    winner_d       = winner_q;
    write_done_d   = 1'b0;
    illegal_move_d = 1'b0;
    if (bus.clear) begin
      state_d      = PLAY;
      board_d      = '0;
      move_count_d = 4'd0;
      winner_d     = 2'b00;
    end else begin
      if (accept) begin
        for (int k = 1; k <= 9; k++) begin
          if (sel[k[3:0]]) board_d[k[3:0]] = p_any ? 2'b01 : 2'b10;
        end
        move_count_d = (move_count_q == 4'd9) ? 4'd9 : move_count_q + 4'd1;
        write_done_d = 1'b1;
        state_d      = EVAL;
      end else if (request) begin
        illegal_move_d = 1'b1;
      end
      if (state_q == EVAL) begin
        winner_d = evaluate(board_q, move_count_q);
        state_d  = (winner_d != 2'b00) ? OVER : PLAY;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q        <= PLAY;
      board_q        <= '0;
      move_count_q   <= 4'd0;
      winner_q       <= 2'b00;
      write_done_q   <= 1'b0;
      illegal_move_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      board_q        <= board_d;
      move_count_q   <= move_count_d;
      winner_q       <= winner_d;
      write_done_q   <= write_done_d;
      illegal_move_q <= illegal_move_d;
    end
  end

  assign bus.board        = board_q;
  assign bus.write_done   = write_done_q;
  assign bus.illegal_move = illegal_move_q;
  assign bus.move_count   = move_count_q;
  assign bus.board_full   = (move_count_q == 4'd9);
  assign bus.winner       = winner_q;
  assign bus.game_over    = (winner_q != 2'b00);
endmodule

// File: tb/tb_position_register_file.sv
// Directed plus randomized bench for position_register_file against a
// cell-array game model evaluated once per clock.
module tb_position_register_file;
  logic clock;
  logic reset;
  position_register_file_if bus ();

  position_register_file dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam int LINES [8][3] = '{'{1,2,3}, '{4,5,6}, '{7,8,9}, '{1,4,7},
                                  '{2,5,8}, '{3,6,9}, '{1,5,9}, '{3,5,7}};

  int total = 0;
  int bad   = 0;

  int   m_cell [10];
  int   m_count;
  int   m_win;
  bit   m_eval;
  logic exp_wd, exp_il;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int judge();
    bit pl = 0;
    bit co = 0;
    for (int i = 0; i < 8; i++) begin
      int a = m_cell[LINES[i][0]];
      if (a != 0 && a == m_cell[LINES[i][1]] && a == m_cell[LINES[i][2]]) begin
        if (a == 1) pl = 1; else co = 1;
      end
    end
    if (pl) return 1;
    if (co) return 2;
    if (m_count == 9) return 3;
    return 0;
  endfunction

  function automatic logic [17:0] exp_board();
    logic [17:0] b = '0;
    for (int k = 1; k <= 9; k++) b = b | (18'(m_cell[k]) << (2 * (k - 1)));
    return b;
  endfunction

  // Apply one cycle of inputs, advance the model, compare every output.
  task automatic step(input logic [15:0] pe, input logic [15:0] ce,
                      input logic clr, input logic rn, input string tag);
    bit was_eval, was_over, ok;
    logic [15:0] v;
    int k;
    bus.player_en   = pe;
    bus.computer_en = ce;
    bus.clear       = clr;
    reset           = rn;
    exp_wd = 1'b0;
    exp_il = 1'b0;
    if (!rn || clr) begin
      for (int i = 0; i < 10; i++) m_cell[i] = 0;
      m_count = 0;
      m_win   = 0;
      m_eval  = 0;
    end else begin
      was_eval = m_eval;
      was_over = (m_win != 0);
      if (m_eval) begin
        m_win  = judge();
        m_eval = 0;
      end
      if (pe != 0 || ce != 0) begin
        ok = !was_eval && !was_over && ((pe == 0) != (ce == 0));
        v  = (pe != 0) ? pe : ce;
        k  = -1;
        if ($countones(v) != 1) ok = 0;
        else begin
          for (int i = 0; i < 16; i++) if (v[i]) k = i;
          if (k < 1 || k > 9) ok = 0;
          else if (m_cell[k] != 0) ok = 0;
        end
        if (ok) begin
          m_cell[k] = (pe != 0) ? 1 : 2;
          m_count++;
          m_eval = 1;
          exp_wd = 1'b1;
        end else begin
          exp_il = 1'b1;
        end
      end
    end
    @(posedge clock);
    #1;
    chk({tag, ".board"},        32'(bus.board),        32'(exp_board()));
    chk({tag, ".write_done"},   32'(bus.write_done),   32'(exp_wd));
    chk({tag, ".illegal_move"}, 32'(bus.illegal_move), 32'(exp_il));
    chk({tag, ".move_count"},   32'(bus.move_count),   32'(m_count));
    chk({tag, ".board_full"},   32'(bus.board_full),   32'(m_count == 9));
    chk({tag, ".winner"},       32'(bus.winner),       32'(m_win));
    chk({tag, ".game_over"},    32'(bus.game_over),    32'(m_win != 0));
  endtask

  function automatic logic [15:0] cell_bit(input int k);
    return 16'(1) << k;
  endfunction

  task automatic move(input bit player, input int k, input string tag);
    if (player) step(cell_bit(k), 16'h0, 1'b0, 1'b1, tag);
    else        step(16'h0, cell_bit(k), 1'b0, 1'b1, tag);
    step(16'h0, 16'h0, 1'b0, 1'b1, {tag, "_eval"});
  endtask

  initial begin
    bus.player_en   = '0;
    bus.computer_en = '0;
    bus.clear       = 1'b0;
    reset           = 1'b0;

    // Reset, then single move on cell 5
    step(16'h0, 16'h0, 1'b0, 1'b0, "reset0");
    step(16'h0, 16'h0, 1'b0, 1'b0, "reset1");
    step(16'h0020, 16'h0, 1'b0, 1'b1, "first_move");
    chk("first_board_const", 32'(bus.board), 32'h00100);
    step(16'h0, 16'h0, 1'b0, 1'b1, "first_eval");
    step(16'h0, 16'h0, 1'b0, 1'b1, "first_idle");

    // Rejected requests
    step(16'h0, 16'h0020, 1'b0, 1'b1, "rej_occupied");
    step(16'h0001, 16'h0, 1'b0, 1'b1, "rej_bit0");
    step(16'h0400, 16'h0, 1'b0, 1'b1, "rej_bit10");
    step(16'h0006, 16'h0, 1'b0, 1'b1, "rej_two_bits");
    step(16'h0002, 16'h0004, 1'b0, 1'b1, "rej_both");
    step(16'h0, 16'h0, 1'b0, 1'b1, "rej_idle");

    // Player row win
    step(16'h0, 16'h0, 1'b1, 1'b1, "row_clear");
    move(1, 1, "row_x1");
    move(0, 4, "row_o4");
    move(1, 2, "row_x2");
    move(0, 5, "row_o5");
    move(1, 3, "row_x3");
    chk("row_winner_const", 32'(bus.winner), 32'd1);
    step(16'h0200, 16'h0, 1'b0, 1'b1, "row_after_over");

    // Draw
    step(16'h0, 16'h0, 1'b1, 1'b1, "draw_clear");
    move(1, 1, "d_x1"); move(0, 2, "d_o2"); move(1, 3, "d_x3");
    move(0, 5, "d_o5"); move(1, 4, "d_x4"); move(0, 6, "d_o6");
    move(1, 8, "d_x8"); move(0, 7, "d_o7"); move(1, 9, "d_x9");
    chk("draw_winner_const", 32'(bus.winner), 32'd3);
    chk("draw_full_const",   32'(bus.board_full), 32'd1);

    // Clear during OVER together with a request, then a fresh move
    step(16'h0020, 16'h0, 1'b1, 1'b1, "clr_over_req");
    chk("clr_board_const", 32'(bus.board), 32'd0);
    step(16'h0020, 16'h0, 1'b0, 1'b1, "clr_next_move");

    // Request in the cycle right after write_done
    step(16'h0, 16'h0002, 1'b0, 1'b1, "eval_request");
    step(16'h0, 16'h0, 1'b0, 1'b1, "eval_idle");

    // Mid-game reset, reset during EVAL, then accepted request
    move(0, 1, "mg_o1");
    step(16'h0008, 16'h0, 1'b0, 1'b1, "mg_x3");
    step(16'h0, 16'h0, 1'b0, 1'b0, "mg_reset_in_eval");
    step(16'h0008, 16'h0, 1'b0, 1'b1, "mg_after_reset");
    step(16'h0, 16'h0, 1'b0, 1'b1, "mg_eval");

    // Randomized play and abuse
    for (int n = 0; n < 800; n++) begin
      int r = $urandom_range(0, 99);
      logic [15:0] a = 16'($urandom);
      logic [15:0] b = 16'($urandom);
      if (r < 2)                        step(16'h0, 16'h0, 1'b0, 1'b0, "rnd_reset");
      else if (r < 4 || (m_win != 0 && r < 20))
                                        step(a, b, 1'b1, 1'b1, "rnd_clear");
      else if (r < 35)                  step(16'h0, 16'h0, 1'b0, 1'b1, "rnd_idle");
      else if (r < 85) begin
        int k = $urandom_range(0, 15);
        if ($urandom_range(0, 1) == 1) step(cell_bit(k), 16'h0, 1'b0, 1'b1, "rnd_px");
        else                           step(16'h0, cell_bit(k), 1'b0, 1'b1, "rnd_co");
      end else if (r < 92)              step(a, 16'h0, 1'b0, 1'b1, "rnd_noise_p");
      else                              step(a, b, 1'b0, 1'b1, "rnd_noise_pc");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
